anemo_cpu_debug_ocimem_arbiter: RTL
===================================

// Module: anemo_cpu_debug_ocimem_arbiter
// PURPOSE
//  Sysclk-domain controller sharing the CPU on-chip debug RAM (OCI RAM) between the JTAG
//  debug slave and the CPU-side Avalon debug memory slave. Decodes take_action_ocimem_a/b,
//  take_no_action_ocimem_a and jdo from the debug slave, sequences single-word RAM accesses,
//  and returns MonDReg/monitor_ready/monitor_error to the debug slave TCK logic.
// PARAMETERS
//  ADDR_W      8      OCI RAM word-address width
//  PROT_BASE   8'hC0  first word address of the write-protected region (see CONFIGURATION)
// PORTS
//  clk                      in   1       system clock
//  reset_n                  in   1       synchronous, active-low reset
//  take_action_ocimem_a     in   1       1-cycle pulse: load address from jdo, issue read
//  take_no_action_ocimem_a  in   1       1-cycle pulse: increment address, issue read
//  take_action_ocimem_b     in   1       1-cycle pulse: write jdo data, then increment address
//  jdo                      in   38      JTAG data: addr=jdo[ADDR_W+1:2], wdata=jdo[34:3]
//  av_address               in   ADDR_W  Avalon word address
//  av_read / av_write       in   1       Avalon read/write strobes, held until !av_waitrequest
//  av_writedata             in   32      Avalon write data
//  av_waitrequest           out  1       (av_read|av_write) & ~av_ack
//  av_readdata              out  32      valid in the cycle av_waitrequest falls on a read
//  ram_addr                 out  ADDR_W  OCI RAM address
//  ram_rd / ram_wr          out  1       RAM strobes; ram_rdata valid 1 cycle after ram_rd
//  ram_wdata                out  32      RAM write data
//  ram_rdata                in   32      RAM read data
//  MonDReg                  out  32      last JTAG read data
//  monitor_ready            out  1       JTAG access complete
//  monitor_error            out  1       JTAG request overrun
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): FSM=IDLE, MonAReg=0, MonDReg=0, monitor_ready=1,
//   monitor_error=0, av_ack=0, jtag_pend=0, last_grant=AV, av_readdata=0; ram_rd/ram_wr=0.
//   A reset mid-access drops it: no RAM strobe after reset, pending JTAG request discarded.
//  JTAG slot (single entry): on an ocimem pulse -> jtag_pend=1, monitor_ready=0;
//   ocimem_a: MonAReg<=jdo addr; no_action_a: MonAReg<=MonAReg+1 (wraps 2^ADDR_W-1 -> 0);
//   ocimem_b: captures wdata; address increment applied when the write completes.
//   Pulse while jtag_pend=1 -> request ignored, monitor_error<=1; cleared only by
//   take_action_ocimem_a when accepted (slot free).
//  FSM states: IDLE, GNT_J, GNT_A, DAT_J, DAT_A.
//   IDLE: jtag_pend only -> GNT_J; Avalon req only (av_read|av_write, ~av_ack) -> GNT_A;
//    both -> the side opposite last_grant (round-robin); none -> IDLE.
//   GNT_x: drive ram_addr (+ram_rd or ram_wr/ram_wdata) for exactly 1 cycle; update last_grant.
//    Write -> IDLE (JTAG: jtag_pend<=0, monitor_ready<=1, MonAReg+1; AV: av_ack<=1).
//    Read  -> DAT_x.
//   DAT_J: MonDReg<=ram_rdata, monitor_ready<=1, jtag_pend<=0 -> IDLE.
//   DAT_A: av_readdata<=ram_rdata, av_ack<=1 -> IDLE.
//  av_ack is a 1-cycle pulse; Avalon master sees !av_waitrequest that cycle.
//  JTAG read latency: pulse at T -> GNT_J at T+2 -> MonDReg/monitor_ready valid at T+4.
//  Avalon read: req at T (FSM idle) -> GNT_A T+1 -> DAT_A T+2 -> av_waitrequest low at T+3.
//  JTAG pulse arriving while its grant is in flight counts as overrun (jtag_pend still 1).
//  At most one RAM strobe per cycle; ram_rd and ram_wr never both high.
// CONFIGURATION
//  ANEMO_OCIMEM_WRPROT_EN defined: Avalon writes with av_address >= PROT_BASE are
//   acknowledged (av_ack) without asserting ram_wr; JTAG writes are never protected.
//  Undefined: all Avalon writes reach the RAM; PROT_BASE unused.
// TESTING
//  ocimem_a with addr 0x10, RAM[0x10]=0xDEADBEEF -> ram_rd at T+2, MonDReg=0xDEADBEEF,
//   monitor_ready=1 at T+4.
//  MonAReg=0xFF, no_action_a -> ram_addr=0x00 (wrap), MonDReg=RAM[0x00].
//  Simultaneous JTAG read + Avalon write, last_grant=AV -> JTAG granted first, Avalon next
//   cycle after JTAG completes; repeat -> order alternates.
//  Second ocimem pulse 1 cycle after first -> monitor_error=1, single RAM access; next
//   accepted ocimem_a -> monitor_error=0.
//  With ANEMO_OCIMEM_WRPROT_EN: Avalon write 0x12345678 to 0xC4 -> av_waitrequest drops,
//   no ram_wr, RAM[0xC4] unchanged; 0x40 -> ram_wr issued and RAM written.
//  reset_n=0 in GNT_J of a read -> no DAT_J capture, MonDReg=0, monitor_ready=1, FSM=IDLE.

Source files
------------

// File: rtl/anemo_cpu_debug_ocimem_arbiter.sv
// OCI RAM arbiter: shares debug RAM between JTAG ocimem slot and Avalon slave.
// Optional ANEMO_OCIMEM_WRPROT_EN blocks Avalon writes at/above PROT_BASE.
module anemo_cpu_debug_ocimem_arbiter #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] PROT_BASE = 8'hC0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  output logic              av_waitrequest,
  output logic [31:0]       av_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GNT_J = 3'd1;
  localparam logic [2:0] GNT_A = 3'd2;
  localparam logic [2:0] DAT_J = 3'd3;
  localparam logic [2:0] DAT_A = 3'd4;

  localparam logic LG_J  = 1'b0;
  localparam logic LG_AV = 1'b1;

`ifdef ANEMO_OCIMEM_WRPROT_EN
  localparam logic WRPROT = 1'b1;
`else
  localparam logic WRPROT = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              ack_q, ack_d;
  logic              pend_q, pend_d;
  logic              jwr_q, jwr_d;
  logic [31:0]       jwdata_q, jwdata_d;
  logic              last_q, last_d;
  logic [31:0]       av_rdata_q, av_rdata_d;

  logic jtag_pulse;
  logic av_req;
  logic wr_prot;
  logic unused_jdo;

  assign jtag_pulse = take_action_ocimem_a
                    | take_no_action_ocimem_a
                    | take_action_ocimem_b;
  assign av_req     = (av_read | av_write) & ~ack_q;
  assign wr_prot    = WRPROT & (av_address >= PROT_BASE);
  assign unused_jdo = ^{jdo[37:35], jdo[1:0]};

  assign av_waitrequest = (av_read | av_write) & ~ack_q;
  assign av_readdata    = av_rdata_q;
  assign MonDReg        = mon_d_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = err_q;

  always_comb begin
    state_d    = state_q;
    mon_a_d    = mon_a_q;
    mon_d_d    = mon_d_q;
    ready_d    = ready_q;
    err_d      = err_q;
    ack_d      = 1'b0;
    pend_d     = pend_q;
    jwr_d      = jwr_q;
    jwdata_d   = jwdata_q;
    last_d     = last_q;
    av_rdata_d = av_rdata_q;
    ram_addr   = mon_a_q;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    ram_wdata  = '0;

    // Single-entry JTAG slot; a pulse while occupied is an overrun.
    if (jtag_pulse) begin
      if (pend_q) begin
        err_d = 1'b1;
      end else begin
        pend_d  = 1'b1;
        ready_d = 1'b0;
        jwr_d   = 1'b0;
        if (take_action_ocimem_a) begin
          mon_a_d = jdo[ADDR_W+1:2];
          err_d   = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          mon_a_d = mon_a_q + 1'b1;
        end else begin
          jwr_d    = 1'b1;
          jwdata_d = jdo[34:3];
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pend_q && (!av_req || last_q == LG_AV)) begin
          state_d = GNT_J;
          last_d  = LG_J;
        end else if (av_req) begin
          state_d = GNT_A;
          last_d  = LG_AV;
        end
      end
      GNT_J: begin
        ram_addr = mon_a_q;
        if (jwr_q) begin
          ram_wr    = 1'b1;
          ram_wdata = jwdata_q;
          pend_d    = 1'b0;
          ready_d   = 1'b1;
          mon_a_d   = mon_a_q + 1'b1;
          state_d   = IDLE;
        end else begin
          ram_rd  = 1'b1;
          state_d = DAT_J;
        end
      end
      GNT_A: begin
        ram_addr = av_address;
        if (av_write) begin
          ram_wr    = ~wr_prot;
          ram_wdata = av_writedata;
          ack_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          ram_rd  = 1'b1;
          state_d = DAT_A;
        end
      end
      DAT_J: begin
        mon_d_d = ram_rdata;
        ready_d = 1'b1;
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      DAT_A: begin
        av_rdata_d = ram_rdata;
        ack_d      = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      pend_q     <= 1'b0;
      jwr_q      <= 1'b0;
      jwdata_q   <= '0;
      last_q     <= LG_AV;
      av_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      pend_q     <= pend_d;
      jwr_q      <= jwr_d;
      jwdata_q   <= jwdata_d;
      last_q     <= last_d;
      av_rdata_q <= av_rdata_d;
    end
  end

endmodule
